// File: rtl/mem_access_stage.sv
// MEM stage of the RV32I pipeline: data-memory handshake, load alignment/extension, store lanes.
// Optional `define MISALIGN_TRAP_EN traps misaligned half/word accesses in IDLE and adds output mem_misalign.
module mem_access_stage #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,
    input  logic [1:0]  ex_wb,
    input  logic [31:0] ex_instruction,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem_valid,
    output logic [31:0] mem_result,
    output logic [4:0]  mem_rd,
    output logic [1:0]  mem_wb,
    output logic [31:0] mem_instruction,
    output logic        mem_bus_err
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        mem_misalign
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic [31:0] addr_q;
    logic        we_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;
    logic [2:0]  funct3_q;
    logic [31:0] load_q;
    logic        err_q;

    logic        memop;
    logic        misalign;
    logic        accept;
    logic [3:0]  wstrb_n;
    logic [31:0] wdata_n;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_aligned;

    assign memop = ex_valid & (ex_mem_read | ex_mem_write);

`ifdef MISALIGN_TRAP_EN
    assign misalign = memop &
                      (((ex_funct3[1:0] == 2'b01) & ex_alu_out[0]) |
                       ((ex_funct3[1:0] == 2'b10) & (ex_alu_out[1:0] != 2'b00)));
    assign mem_misalign = (state == IDLE) & misalign;
`else
    assign misalign = 1'b0;
`endif

    assign accept = (state == IDLE) & memop & ~misalign;

    always_comb begin
        wstrb_n = 4'b1111;
        wdata_n = ex_wdata;
        case (ex_funct3[1:0])
            2'b00: begin
                wstrb_n = 4'b0001 << ex_alu_out[1:0];
                wdata_n = {4{ex_wdata[7:0]}};
            end
            2'b01: begin
                wstrb_n = ex_alu_out[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{ex_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Alignment uses the latched address bits, since ex_alu_out may not be trusted during BUSY.
    always_comb begin
        rd_byte      = dmem_rdata[7:0];
        load_aligned = dmem_rdata;
        case (addr_q[1:0])
            2'b01:   rd_byte = dmem_rdata[15:8];
            2'b10:   rd_byte = dmem_rdata[23:16];
            2'b11:   rd_byte = dmem_rdata[31:24];
            default: rd_byte = dmem_rdata[7:0];
        endcase
        rd_half = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_q[1:0])
            2'b00:   load_aligned = {{24{rd_byte[7] & ~funct3_q[2]}}, rd_byte};
            2'b01:   load_aligned = {{16{rd_half[15] & ~funct3_q[2]}}, rd_half};
            default: load_aligned = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            addr_q   <= 32'd0;
            we_q     <= 1'b0;
            wstrb_q  <= 4'd0;
            wdata_q  <= 32'd0;
            funct3_q <= 3'd0;
            load_q   <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q   <= ex_alu_out;
                        we_q     <= ex_mem_write;
                        wstrb_q  <= ex_mem_write ? wstrb_n : 4'b0000;
                        wdata_q  <= wdata_n;
                        funct3_q <= ex_funct3;
                        cnt      <= 8'd0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    // An ack in the final counted cycle still wins over the timeout.
                    if (dmem_ack) begin
                        if (!we_q) load_q <= load_aligned;
                        state <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    cnt   <= 8'd0;
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        dmem_req        = (state == BUSY);
        dmem_we         = dmem_req & we_q;
        dmem_wstrb      = dmem_we ? wstrb_q : 4'b0000;
        dmem_addr       = {addr_q[31:2], 2'b00};
        dmem_wdata      = wdata_q;
        mem_stall       = ~rst & (accept | (state == BUSY));
        mem_valid       = 1'b0;
        mem_result      = ex_alu_out;
        mem_wb          = ex_wb;
        mem_bus_err     = 1'b0;
        mem_rd          = ex_rd;
        mem_instruction = ex_instruction;
        case (state)
            IDLE: begin
                mem_valid = ex_valid & ~accept;
                if (misalign) mem_wb = 2'b00;
            end
            DONE: begin
                mem_valid = 1'b1;
                if (err_q) begin
                    mem_result  = 32'd0;
                    mem_wb      = 2'b00;
                    mem_bus_err = 1'b1;
                end else if (!we_q) begin
                    mem_result = load_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage against a behavioural memory-access model.
// Build with `define MISALIGN_TRAP_EN to also exercise the misalignment trap.
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_mem_read, ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu_out, ex_wdata, ex_instruction;
    logic [4:0]  ex_rd;
    logic [1:0]  ex_wb;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        mem_stall, mem_valid, mem_bus_err;
    logic [31:0] mem_result, mem_instruction;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wb;
`ifdef MISALIGN_TRAP_EN
    logic        mem_misalign;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_funct3(ex_funct3), .ex_alu_out(ex_alu_out), .ex_wdata(ex_wdata),
        .ex_rd(ex_rd), .ex_wb(ex_wb), .ex_instruction(ex_instruction),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .mem_valid(mem_valid), .mem_result(mem_result),
        .mem_rd(mem_rd), .mem_wb(mem_wb), .mem_instruction(mem_instruction),
        .mem_bus_err(mem_bus_err)
`ifdef MISALIGN_TRAP_EN
        , .mem_misalign(mem_misalign)
`endif
    );

    // Reference model: what a load returns, computed from byte arithmetic on the read word.
    function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [2:0] f3);
        int unsigned v;
        int unsigned a;
        a = addr % 4;
        case (f3)
            3'b000, 3'b100: begin
                v = (word >> (8 * a)) % 256;
                if (f3 == 3'b000 && v >= 128) v = v + 32'hFFFF_FF00;
            end
            3'b001, 3'b101: begin
                v = (word >> (16 * (a / 2))) % 65536;
                if (f3 == 3'b001 && v >= 32768) v = v + 32'hFFFF_0000;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [31:0] addr);
        int unsigned a;
        a = addr % 4;
        case (f3 % 4)
            0:       return 4'(1 << a);
            1:       return (a >= 2) ? 4'd12 : 4'd3;
            default: return 4'd15;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3 % 4)
            0:       return (d % 256) * 32'h0101_0101;
            1:       return (d % 65536) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic bit is_misaligned(input logic [2:0] f3, input logic [31:0] addr);
        return ((f3 % 4) == 1 && (addr % 2) != 0) || ((f3 % 4) == 2 && (addr % 4) != 0);
    endfunction

    task automatic drive_idle();
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_funct3 = 3'd0;
        ex_alu_out = 32'd0; ex_wdata = 32'd0; ex_rd = 5'd0; ex_wb = 2'd0;
        ex_instruction = 32'd0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    endtask

    // One memory instruction; ack_at is the BUSY cycle carrying the ack, outside 1..TO means none.
    task automatic do_mem_access(input string name, input bit is_store, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [31:0] rdata, input int ack_at);
        logic [4:0]  rd;
        logic [1:0]  wb;
        logic [31:0] exp_res;
        bit          timed_out;
        bit          trap;
        int          exp_busy;
        rd = 5'($urandom);
        wb = 2'($urandom_range(1, 3));
        trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
        trap = is_misaligned(f3, addr);
`endif
        @(posedge clk); #1;
        ex_valid = 1'b1;
        ex_mem_write = is_store;
        ex_mem_read = is_store ? 1'($urandom_range(0, 1)) : 1'b1;
        ex_funct3 = f3; ex_alu_out = addr; ex_wdata = wd; ex_rd = rd; ex_wb = wb;
        ex_instruction = $urandom; dmem_ack = 1'b0;
        @(negedge clk);
        if (trap) begin
`ifdef MISALIGN_TRAP_EN
            total++; if (mem_misalign !== 1'b1) begin bad++; $display("[TB] FAIL %s misalign pulse: got %b want 1", name, mem_misalign); end
`endif
            total++; if (mem_stall !== 1'b0) begin bad++; $display("[TB] FAIL %s trap stall: got %b want 0", name, mem_stall); end
            total++; if (dmem_req !== 1'b0) begin bad++; $display("[TB] FAIL %s trap req: got %b want 0", name, dmem_req); end
            total++; if (mem_valid !== 1'b1) begin bad++; $display("[TB] FAIL %s trap valid: got %b want 1", name, mem_valid); end
            total++; if (mem_wb !== 2'b00) begin bad++; $display("[TB] FAIL %s trap wb: got %b want 00", name, mem_wb); end
            total++; if (mem_result !== addr) begin bad++; $display("[TB] FAIL %s trap result: got %h want %h", name, mem_result, addr); end
            @(posedge clk); #1;
            drive_idle();
            @(negedge clk);
            total++; if (dmem_req !== 1'b0) begin bad++; $display("[TB] FAIL %s req after trap: got %b want 0", name, dmem_req); end
            return;
        end
        total++; if (mem_stall !== 1'b1) begin bad++; $display("[TB] FAIL %s accept stall: got %b want 1", name, mem_stall); end
        total++; if (dmem_req !== 1'b0) begin bad++; $display("[TB] FAIL %s accept req: got %b want 0", name, dmem_req); end
        total++; if (mem_valid !== 1'b0) begin bad++; $display("[TB] FAIL %s accept valid: got %b want 0", name, mem_valid); end
`ifdef MISALIGN_TRAP_EN
        total++; if (mem_misalign !== 1'b0) begin bad++; $display("[TB] FAIL %s spurious misalign: got %b want 0", name, mem_misalign); end
`endif
        timed_out = !(ack_at >= 1 && ack_at <= TO);
        exp_busy = timed_out ? TO : ack_at;
        for (int n = 1; n <= exp_busy; n++) begin
            @(posedge clk); #1;
            dmem_ack = (n == ack_at);
            dmem_rdata = (n == ack_at) ? rdata : $urandom;
            @(negedge clk);
            total++; if (dmem_req !== 1'b1) begin bad++; $display("[TB] FAIL %s busy%0d req: got %b want 1", name, n, dmem_req); end
            total++; if (mem_stall !== 1'b1) begin bad++; $display("[TB] FAIL %s busy%0d stall: got %b want 1", name, n, mem_stall); end
            total++; if (mem_valid !== 1'b0) begin bad++; $display("[TB] FAIL %s busy%0d valid: got %b want 0", name, n, mem_valid); end
            total++; if (dmem_addr !== (addr & 32'hFFFF_FFFC)) begin bad++; $display("[TB] FAIL %s busy%0d addr: got %h want %h", name, n, dmem_addr, addr & 32'hFFFF_FFFC); end
            total++; if (dmem_we !== is_store) begin bad++; $display("[TB] FAIL %s busy%0d we: got %b want %b", name, n, dmem_we, is_store); end
            if (is_store) begin
                total++; if (dmem_wstrb !== exp_strb(f3, addr)) begin bad++; $display("[TB] FAIL %s busy%0d wstrb: got %b want %b", name, n, dmem_wstrb, exp_strb(f3, addr)); end
                total++; if (dmem_wdata !== exp_wdata(f3, wd)) begin bad++; $display("[TB] FAIL %s busy%0d wdata: got %h want %h", name, n, dmem_wdata, exp_wdata(f3, wd)); end
            end
        end
        @(posedge clk); #1;
        dmem_ack = timed_out;
        dmem_rdata = $urandom;
        @(negedge clk);
        exp_res = timed_out ? 32'd0 : (is_store ? addr : exp_load(rdata, addr, f3));
        total++; if (dmem_req !== 1'b0) begin bad++; $display("[TB] FAIL %s done req: got %b want 0", name, dmem_req); end
        total++; if (mem_stall !== 1'b0) begin bad++; $display("[TB] FAIL %s done stall: got %b want 0", name, mem_stall); end
        total++; if (mem_valid !== 1'b1) begin bad++; $display("[TB] FAIL %s done valid: got %b want 1", name, mem_valid); end
        total++; if (mem_result !== exp_res) begin bad++; $display("[TB] FAIL %s done result: got %h want %h", name, mem_result, exp_res); end
        total++; if (mem_wb !== (timed_out ? 2'b00 : wb)) begin bad++; $display("[TB] FAIL %s done wb: got %b want %b", name, mem_wb, timed_out ? 2'b00 : wb); end
        total++; if (mem_bus_err !== timed_out) begin bad++; $display("[TB] FAIL %s done bus_err: got %b want %b", name, mem_bus_err, timed_out); end
        total++; if (mem_rd !== rd) begin bad++; $display("[TB] FAIL %s done rd: got %0d want %0d", name, mem_rd, rd); end
        total++; if (dmem_addr !== (addr & 32'hFFFF_FFFC)) begin bad++; $display("[TB] FAIL %s done addr: got %h want %h", name, dmem_addr, addr & 32'hFFFF_FFFC); end
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        #2;
        ex_valid = 1'b1; ex_mem_read = 1'b1;
        #1;
        total++; if (dmem_req !== 1'b0) begin bad++; $display("[TB] FAIL reset req: got %b want 0", dmem_req); end
        total++; if (dmem_we !== 1'b0) begin bad++; $display("[TB] FAIL reset we: got %b want 0", dmem_we); end
        total++; if (dmem_wstrb !== 4'd0) begin bad++; $display("[TB] FAIL reset wstrb: got %b want 0000", dmem_wstrb); end
        total++; if (dmem_addr !== 32'd0) begin bad++; $display("[TB] FAIL reset addr: got %h want 0", dmem_addr); end
        total++; if (mem_stall !== 1'b0) begin bad++; $display("[TB] FAIL reset stall: got %b want 0", mem_stall); end
        total++; if (mem_bus_err !== 1'b0) begin bad++; $display("[TB] FAIL reset bus_err: got %b want 0", mem_bus_err); end
        drive_idle();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_passthrough();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            ex_valid = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            ex_mem_read = 1'b0; ex_mem_write = 1'b0;
            if (i >= 5 && !ex_valid) begin
                ex_mem_read = 1'($urandom_range(0, 1));
                ex_mem_write = !ex_mem_read;
            end
            ex_alu_out = (i == 0) ? 32'h0000_1234 : $urandom;
            ex_wb = (i == 0) ? 2'b10 : 2'($urandom);
            ex_rd = 5'($urandom); ex_funct3 = 3'($urandom); ex_wdata = $urandom;
            ex_instruction = $urandom;
            dmem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            total++; if (mem_result !== ex_alu_out) begin bad++; $display("[TB] FAIL pass%0d result: got %h want %h", i, mem_result, ex_alu_out); end
            total++; if (mem_wb !== ex_wb) begin bad++; $display("[TB] FAIL pass%0d wb: got %b want %b", i, mem_wb, ex_wb); end
            total++; if (mem_valid !== ex_valid) begin bad++; $display("[TB] FAIL pass%0d valid: got %b want %b", i, mem_valid, ex_valid); end
            total++; if (mem_stall !== 1'b0) begin bad++; $display("[TB] FAIL pass%0d stall: got %b want 0", i, mem_stall); end
            total++; if (dmem_req !== 1'b0) begin bad++; $display("[TB] FAIL pass%0d req: got %b want 0", i, dmem_req); end
            total++; if (mem_rd !== ex_rd) begin bad++; $display("[TB] FAIL pass%0d rd: got %0d want %0d", i, mem_rd, ex_rd); end
            total++; if (mem_instruction !== ex_instruction) begin bad++; $display("[TB] FAIL pass%0d instr: got %h want %h", i, mem_instruction, ex_instruction); end
        end
        drive_idle();
    endtask

    task automatic test_directed();
        do_mem_access("lb_0x103", 1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_0000, 2);
        do_mem_access("lhu_0x202", 1'b0, 3'b101, 32'h0000_0202, 32'd0, 32'hBEEF_1234, 1);
        do_mem_access("sb_0x3", 1'b1, 3'b000, 32'h0000_0003, 32'h0000_00AB, 32'd0, 3);
        do_mem_access("sh_0x2", 1'b1, 3'b001, 32'h0000_0002, 32'h1234_5678, 32'd0, 1);
        do_mem_access("lw_last_ack", 1'b0, 3'b010, 32'h0000_0010, 32'd0, 32'hCAFE_F00D, TO);
        drive_idle();
    endtask

    task automatic test_timeout();
        do_mem_access("lw_timeout", 1'b0, 3'b010, 32'h0000_0040, 32'd0, 32'h1111_2222, 0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            drive_idle();
            dmem_ack = 1'b1;
            @(negedge clk);
            total++; if (dmem_req !== 1'b0) begin bad++; $display("[TB] FAIL late_ack%0d req: got %b want 0", i, dmem_req); end
            total++; if (mem_bus_err !== 1'b0) begin bad++; $display("[TB] FAIL late_ack%0d bus_err: got %b want 0", i, mem_bus_err); end
            total++; if (mem_valid !== 1'b0) begin bad++; $display("[TB] FAIL late_ack%0d valid: got %b want 0", i, mem_valid); end
        end
        drive_idle();
    endtask

    task automatic test_reset_mid_access();
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
        ex_funct3 = 3'b010; ex_alu_out = 32'h0000_0080; ex_wb = 2'b01;
        @(posedge clk); #1;
        total++; if (dmem_req !== 1'b1) begin bad++; $display("[TB] FAIL rst_mid pre req: got %b want 1", dmem_req); end
        #1 rst = 1'b1;
        #1;
        total++; if (dmem_req !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid req: got %b want 0", dmem_req); end
        total++; if (mem_stall !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid stall: got %b want 0", mem_stall); end
        drive_idle();
        @(negedge clk);
        rst = 1'b0;
        do_mem_access("lw_after_rst", 1'b0, 3'b010, 32'h0000_0084, 32'd0, 32'h8765_4321, 2);
        drive_idle();
    endtask

    task automatic test_back_to_back();
        do_mem_access("b2b_sw", 1'b1, 3'b010, 32'h0000_1000, 32'hA5A5_5A5A, 32'd0, 1);
        do_mem_access("b2b_lb", 1'b0, 3'b000, 32'h0000_1001, 32'd0, 32'h0000_7F00, 1);
        do_mem_access("b2b_lh", 1'b0, 3'b001, 32'h0000_1002, 32'd0, 32'h9ABC_0000, 2);
        do_mem_access("b2b_to", 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00EE, 32'd0, 0);
        drive_idle();
    endtask

    task automatic test_random();
        logic [2:0] load_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int i = 0; i < 40; i++) begin
            bit st;
            logic [2:0] f3;
            st = 1'($urandom_range(0, 1));
            f3 = st ? 3'($urandom_range(0, 2)) : load_f3[$urandom_range(0, 4)];
            do_mem_access($sformatf("rand%0d", i), st, f3, $urandom, $urandom, $urandom,
                          $urandom_range(1, TO + 1));
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
                drive_idle();
            end
        end
        drive_idle();
    endtask

`ifdef MISALIGN_TRAP_EN
    task automatic test_misalign();
        do_mem_access("lw_0x6_trap", 1'b0, 3'b010, 32'h0000_0006, 32'd0, 32'd0, 1);
        do_mem_access("sh_0x5_trap", 1'b1, 3'b001, 32'h0000_0005, 32'h0000_BEEF, 32'd0, 1);
        drive_idle();
    endtask
`endif

    initial begin
        test_reset();
        test_passthrough();
        test_directed();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        test_random();
`ifdef MISALIGN_TRAP_EN
        test_misalign();
`endif
        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage RV32I pipeline, between the EX/MEM register and the MEM_WB pipeline register.
- Loads: drives the data-memory req/ack handshake, aligns load data and sign/zero-extends it.
- Stores: generates byte strobes and lane-replicated write data.
- Stalls the upstream pipeline while a memory access is outstanding. Non-memory instructions pass through combinationally.

Parameters:
- ACK_TIMEOUT, 255: max BUSY cycles without dmem_ack before the access is aborted (1..255).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- ex_valid  in  1  EX/MEM holds a live instruction
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- ex_alu_out  in  32  ALU result / effective address
- ex_wdata  in  32  store data (rs2)
- ex_rd  in  5  destination register
- ex_wb  in  2  WB control
- ex_instruction  in  32  instruction word
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address, {addr[31:2],2'b00}
- dmem_wstrb  out  4  byte write strobes
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  access complete; rdata valid on loads
- dmem_rdata  in  32  read word
- mem_stall  out  1  hold EX/MEM and all upstream stages
- mem_valid  out  1  outputs valid for MEM_WB capture
- mem_result  out  32  load data or ALU result
- mem_rd  out  5  = ex_rd
- mem_wb  out  2  WB control (forced 00 on error)
- mem_instruction  out  32  = ex_instruction
- mem_bus_err  out  1  1-cycle pulse: access timed out

Behaviour:
- Reset is asynchronous, active-high, rst; clock clk.
- Reset values: state IDLE, timeout counter 0, address/data/funct3 latches 0, load_q 0, err_q 0. Therefore dmem_req 0, dmem_we 0, dmem_wstrb 0, mem_stall 0, mem_bus_err 0.
- Let memop = ex_valid & (ex_mem_read | ex_mem_write).
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If memop: latch addr, we, wstrb, wdata, funct3; go to BUSY. mem_stall=1 this cycle.
  - Otherwise: pass-through. mem_result=ex_alu_out, mem_valid=ex_valid.
- BUSY:
  - dmem_req=1 with latched fields held stable; mem_stall=1; counter increments.
  - On dmem_ack: load_q ← aligned dmem_rdata (loads only); go to DONE.
  - If counter reaches ACK_TIMEOUT-1 without ack: err_q=1; go to DONE.
- DONE (exactly 1 cycle):
  - mem_stall=0, mem_valid=1.
  - mem_result = load_q for loads, ex_alu_out for stores.
  - If err_q: mem_wb=00, mem_result=0, mem_bus_err=1.
  - Next state IDLE; counter and err_q clear. DONE never re-accepts.
- Latency: non-mem 0 cycles. Mem access = 1 accept cycle + N BUSY cycles (N ≥ 1, ack included) + 1 DONE cycle.
- dmem_ack is ignored in IDLE and DONE. A late ack after timeout has no effect.
- Store strobes, using a = addr[1:0]:
  - SB: wstrb = 1<<a; wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 0011 if a[1]=0, else 1100; wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 1111.
- Loads: select byte a or half a[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW takes the word.
- ex_mem_read and ex_mem_write both set: treated as a store.
- Reset mid-access: immediate return to IDLE, dmem_req drops asynchronously. The in-flight access is abandoned.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠00, are detected in IDLE. For such accesses:
  - no request is issued, no stall;
  - mem_valid=1, mem_wb=00, mem_result=ex_alu_out;
  - extra output mem_misalign (1 bit) pulses for that cycle.
- Undefined: port absent. Offending low address bits are ignored (half uses addr[1], word uses the aligned word) and the access proceeds normally.

Test Plan:
- Non-mem op: ex_valid=1, ex_alu_out=0x1234, ex_wb=10 → same cycle mem_result=0x1234, mem_wb=10, mem_stall=0, dmem_req=0.
- LB, addr 0x103, rdata 0x80FF_0000, ack after 2 BUSY cycles:
  - mem_stall=1 for 3 cycles;
  - DONE: mem_result=0xFFFF_FF80, dmem_addr=0x100.
- LHU, addr 0x202, rdata 0xBEEF_1234 → mem_result=0x0000_BEEF.
- SB, addr 0x3, ex_wdata=0xAB → dmem_we=1, wstrb=1000, wdata=0xABAB_ABAB.
- SH, addr 0x2 → wstrb=1100.
- Timeout: ACK_TIMEOUT=4, no ack:
  - dmem_req high 4 cycles;
  - DONE: mem_bus_err=1, mem_wb=00, mem_result=0;
  - ack arriving afterwards is ignored.
- rst asserted in BUSY → dmem_req=0 and mem_stall=0 immediately. After release, a new LW completes normally.
- MISALIGN_TRAP_EN: LW addr 0x6 → mem_misalign=1, dmem_req never asserted, mem_wb=00.
